apb_cmd_bridge: RTL and testbench
=================================

# apb_cmd_bridge

Upstream command-to-APB sequencer that feeds the four-slave APB fabric. Accepts read/write commands on a valid/ready interface, buffers them in a small FIFO, and drives the APB SETUP/ACCESS protocol (psel, penable, paddr, pwrite, pwdata, pstrb, pprot) toward the slaves. Returns read data and error status on a valid/ready response interface. It replaces the testbench-driven psel/paddr stimulus as the fabric's sole requester.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN)
- pclk  in  1  clock, all state on rising edge
- preset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = !full && !preset
- cmd_addr  in  32  byte address; [31:30] selects slave
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  captured pslverr (or timeout)
- psel  out  4  one-hot slave select
- penable  out  1  ACCESS phase
- paddr  out  32  transfer address
- pwrite  out  1  transfer direction
- pwdata  out  32  write data
- pstrb  out  4  strobes; forced 0 on reads
- pprot  out  3  protection
- prdata  in  32  read data from selected slave
- pready  in  1  slave ready
- pslverr  in  1  slave error
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- Command accepted on rising edge with cmd_valid && cmd_ready; pushed into FIFO (addr, write, wdata, strb, prot).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if FIFO non-empty and response slot free (rsp_valid==0, or rsp_valid && rsp_ready this cycle) -> SETUP; FIFO head loaded into APB output registers on this edge.
- SETUP: psel = one-hot of paddr[31:30] (00->0001, 01->0010, 10->0100, 11->1000), penable=0; unconditionally -> ACCESS.
- ACCESS: penable=1, psel/paddr/pwrite/pwdata/pstrb/pprot held stable. On pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, set rsp_valid, pop FIFO, -> IDLE. pready=0: stay.
- Leaving ACCESS: psel=0, penable=0, paddr/pwdata retain last value.
- Response slot: rsp_valid cleared on rsp_valid && rsp_ready unless refilled on same edge (refill wins, valid stays 1).
- Simultaneous push and pop: both occur; count unchanged. Push when full: ignored (cmd_ready=0).
- pprot/pstrb passed through; pstrb=0 whenever pwrite=0.
- Reset (async, any time, including mid-ACCESS): FIFO emptied, state IDLE, all outputs 0; in-flight transfer dropped, no response generated.

## Timing
- All APB and rsp outputs registered; cmd_ready combinational from FIFO count and preset.
- Reset values: every output 0 (cmd_ready 0 while preset high, 1 on first cycle after release).
- Command accepted at edge E0: SETUP visible after E1, ACCESS after E2; with pready=1 in first ACCESS cycle, rsp_valid=1 after E3. Minimum latency 3 cycles.
- Each additional ACCESS cycle with pready=0 adds 1 cycle.
- Back-to-back commands with rsp_ready held 1: one transfer per 3 cycles (IDLE, SETUP, ACCESS).
- rsp_valid held with stable data until rsp_ready; next transfer does not start SETUP while slot occupied.

## Configuration
- APB_TIMEOUT_EN defined: counter clears on SETUP, increments each ACCESS cycle with pready=0; when it reaches TIMEOUT_CYCLES, transfer is terminated on that edge: psel/penable deassert, rsp_rdata=0, rsp_err=1, rsp_valid=1, FIFO popped, -> IDLE. A pready arriving on the same edge as expiry wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely for pready.

## Test plan
- Single write 0x4000_0010 data 0xDEAD_BEEF strb 0xF, pready=1 immediately -> psel=0010 in SETUP, penable=1 next cycle, rsp_valid after 3 cycles, rsp_rdata=0, rsp_err=0.
- Read 0xC000_0004, pready low 2 ACCESS cycles, prdata=0x1234_5678 -> psel=1000, paddr stable throughout, pstrb=0, rsp_rdata=0x1234_5678 on 5th cycle.
- Push 5 commands with rsp_ready=0, FIFO_DEPTH=4 -> cmd_ready falls after 4th accepted (first goes to APB, then FIFO refills); no second SETUP until rsp consumed; all responses in order.
- Read with pslverr=1 at pready -> rsp_err=1; subsequent transfer unaffected.
- preset pulsed during ACCESS -> psel/penable/rsp_valid 0 immediately, busy=0, no stale response after release.
- With APB_TIMEOUT_EN, pready held 0 -> termination after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; without macro, still waiting at cycle 100.

Source files
------------

// File: rtl/apb_cmd_bridge.sv
// ---------------------------------------------------------------------------
// apb_cmd_bridge
//
// Single requester for the four-slave APB fabric. Commands arrive on a
// valid/ready interface and are buffered in a small FIFO. The head command
// is turned into an APB SETUP/ACCESS transfer. Its completion status is
// returned on a valid/ready response interface that holds one entry.
//
// The FIFO head stays in the FIFO while its transfer is in flight and is
// popped when the transfer completes. A queued command therefore counts
// against FIFO_DEPTH until its response has been generated.
//
// Parameters
//   FIFO_DEPTH      command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  ACCESS-phase stall limit (used with APB_TIMEOUT_EN)
//
// Optional feature macro
//   APB_TIMEOUT_EN  when defined, a transfer that stalls TIMEOUT_CYCLES
//                   ACCESS cycles is ended with rsp_err=1, rsp_rdata=0.
//
// Ports
//   pclk, preset        clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (cmd_ready = !full && !preset)
//   cmd_addr/write/wdata/strb/prot   command payload
//   rsp_valid/ready     response handshake
//   rsp_rdata, rsp_err  read data (0 for writes) and slave error / timeout
//   psel..pprot         APB requester outputs (all registered)
//   prdata, pready, pslverr          APB completer inputs
//   busy                transfer in progress or commands queued
// ---------------------------------------------------------------------------
module apb_cmd_bridge #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  psel,
  output logic        penable,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 72;  // addr(32) + write(1) + wdata(32) + strb(4) + prot(3)

  // Parameter legality, reported at elaboration.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_cmd_bridge: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_cmd_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Slave select decode from the two top address bits.
  function automatic logic [3:0] slave_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      2'b00:   oh = 4'b0001;
      2'b01:   oh = 4'b0010;
      2'b10:   oh = 4'b0100;
      2'b11:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  state_t        state;
  state_t        state_next;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [EW-1:0] head;
  logic [31:0]   head_addr;
  logic          head_write;
  logic [31:0]   head_wdata;
  logic [3:0]    head_strb;
  logic [2:0]    head_prot;

  logic          slot_free;
  logic          start;
  logic          enter_access;
  logic          access_ok;
  logic          expire;
  logic          done;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign cmd_ready = !full && !preset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = done;
  assign busy      = (state != ST_IDLE) || !empty;

  // The response slot can take a new entry if empty or drained this edge.
  assign slot_free = !rsp_valid || rsp_ready;

  assign head       = mem[rd_ptr];
  assign head_addr  = head[71:40];
  assign head_write = head[39];
  assign head_wdata = head[38:7];
  assign head_strb  = head[6:3];
  assign head_prot  = head[2:0];

  // FIFO storage; entries are only read while the FIFO is non-empty.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts stalled ACCESS cycles of the transfer in flight.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt <= {TW{1'b0}};
    end else if (state == ST_SETUP) begin
      tmo_cnt <= {TW{1'b0}};
    end else if (state == ST_ACCESS && !pready) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  // Expiry fires on the edge that ends the last allowed stall cycle;
  // a pready on that same edge is a normal completion instead.
  assign expire = (state == ST_ACCESS) && !pready &&
                  (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  assign done = access_ok || expire;

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (done) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ACCESS;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state control decode that steers the registered outputs.
  always_comb begin
    start        = 1'b0;
    enter_access = 1'b0;
    access_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && slot_free) begin
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      ST_SETUP: enter_access = 1'b1;
      ST_ACCESS: begin
        if (pready) begin
          access_ok = 1'b1;
        end else begin
          access_ok = 1'b0;
        end
      end
      default: begin
        start        = 1'b0;
        enter_access = 1'b0;
        access_ok    = 1'b0;
      end
    endcase
  end

  // APB request registers: loaded from the FIFO head when a transfer starts.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel    <= 4'b0000;
      penable <= 1'b0;
      paddr   <= 32'h0000_0000;
      pwrite  <= 1'b0;
      pwdata  <= 32'h0000_0000;
      pstrb   <= 4'b0000;
      pprot   <= 3'b000;
    end else if (start) begin
      psel    <= slave_onehot(head_addr[31:30]);
      penable <= 1'b0;
      paddr   <= head_addr;
      pwrite  <= head_write;
      pwdata  <= head_wdata;
      pstrb   <= head_write ? head_strb : 4'b0000;
      pprot   <= head_prot;
    end else if (enter_access) begin
      penable <= 1'b1;
    end else if (done) begin
      psel    <= 4'b0000;
      penable <= 1'b0;
    end
  end

  // Response slot: a completing transfer refills it even while it drains.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (access_ok && !pwrite) ? prdata : 32'h0000_0000;
      rsp_err   <= access_ok ? pslverr : 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// ---------------------------------------------------------------------------
// Self-checking bench for apb_cmd_bridge. A transaction-level model (command
// queue, transfer phase, response slot) predicts every output each cycle.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_apb_cmd_bridge;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'h0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_strb = 4'h0;
  logic [2:0]  cmd_prot = 3'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        busy;

  always #5 pclk = ~pclk;

  apb_cmd_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_t;

  // Reference model: commands accepted and not yet answered (head is the
  // one on the bus), transfer phase 0=idle 1=setup 2=access, response slot.
  cmd_t        q[$];
  int          phase = 0;
  int          stall_cnt = 0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = 32'h0;
  logic        m_re = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model state.
  task automatic compare();
    logic [3:0] sel_exp;
    check_eq("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
    check_eq("busy", 32'(busy), 32'(q.size() != 0));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      check_eq("rsp_rdata", rsp_rdata, m_rd);
      check_eq("rsp_err", 32'(rsp_err), 32'(m_re));
    end
    check_eq("penable", 32'(penable), 32'(phase == 2));
    if (phase != 0) begin
      sel_exp = 4'b0001 << q[0].addr[31:30];
      check_eq("psel", 32'(psel), 32'(sel_exp));
      check_eq("paddr", paddr, q[0].addr);
      check_eq("pwrite", 32'(pwrite), 32'(q[0].write));
      check_eq("pwdata", pwdata, q[0].wdata);
      check_eq("pstrb", 32'(pstrb), 32'(q[0].write ? q[0].strb : 4'h0));
      check_eq("pprot", 32'(pprot), 32'(q[0].prot));
    end else begin
      check_eq("psel_idle", 32'(psel), 32'h0);
    end
  endtask

  // Advance one clock: predict the edge from the current inputs and model,
  // then sample the DUT 1 time unit after the edge.
  task automatic step();
    logic        nonempty;
    logic        slot_free;
    logic        acc;
    logic        done;
    logic [31:0] d_rd;
    logic        d_re;
    cmd_t        c;
    nonempty  = (q.size() != 0);
    slot_free = !m_rv || rsp_ready;
    acc       = cmd_valid && (q.size() < DEPTH);
    c         = {cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot};
    done      = 1'b0;
    d_rd      = 32'h0;
    d_re      = 1'b0;
    if (phase == 2) begin
      if (pready) begin
        done = 1'b1;
        d_rd = q[0].write ? 32'h0 : prdata;
        d_re = pslverr;
      end
`ifdef APB_TIMEOUT_EN
      else if (stall_cnt == TMO - 1) begin
        done = 1'b1;
        d_rd = 32'h0;
        d_re = 1'b1;
      end
`endif
    end
    @(posedge pclk);
    #1;
    case (phase)
      0: if (nonempty && slot_free) phase = 1;
      1: begin phase = 2; stall_cnt = 0; end
      default: if (done) phase = 0; else stall_cnt++;
    endcase
    if (done) begin
      void'(q.pop_front());
      m_rv = 1'b1;
      m_rd = d_rd;
      m_re = d_re;
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
    if (acc) q.push_back(c);
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("send_accept", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Pulse reset between clock edges and check the immediate effect.
  task automatic pulse_reset();
    #2;
    preset = 1'b1;
    #1;
    check_eq("rst_psel", 32'(psel), 32'h0);
    check_eq("rst_penable", 32'(penable), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    q.delete();
    phase = 0;
    stall_cnt = 0;
    m_rv = 1'b0;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    #1;
    check_eq("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    check_eq("reset_psel", 32'(psel), 32'h0);
    check_eq("reset_penable", 32'(penable), 32'h0);
    check_eq("reset_paddr", paddr, 32'h0);
    check_eq("reset_pwrite", 32'(pwrite), 32'h0);
    check_eq("reset_pwdata", pwdata, 32'h0);
    check_eq("reset_pstrb", 32'(pstrb), 32'h0);
    check_eq("reset_pprot", 32'(pprot), 32'h0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("reset_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    preset = 1'b0;
    #1;
    check_eq("cmd_ready_release", 32'(cmd_ready), 32'h1);

    // Single write, slave ready immediately: 3-cycle latency
    pready = 1'b1;
    rsp_ready = 1'b1;
    send(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001);
    step();
    check_eq("t1_setup_psel", 32'(psel), 32'h2);
    check_eq("t1_setup_penable", 32'(penable), 32'h0);
    step();
    check_eq("t1_access_penable", 32'(penable), 32'h1);
    step();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("t1_rsp_err", 32'(rsp_err), 32'h0);
    step();

    // Read with two stalled ACCESS cycles
    pready = 1'b0;
    prdata = 32'h1234_5678;
    send(32'hC000_0004, 1'b0, 32'h5555_AAAA, 4'hF, 3'b010);
    step();
    check_eq("t2_psel", 32'(psel), 32'h8);
    check_eq("t2_pstrb", 32'(pstrb), 32'h0);
    steps(3);
    check_eq("t2_still_access", 32'(penable), 32'h1);
    check_eq("t2_paddr", paddr, 32'hC000_0004);
    pready = 1'b1;
    step();
    check_eq("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
    step();

    // Fill the FIFO with the response slot blocked
    rsp_ready = 1'b0;
    pready = 1'b0;
    for (int i = 0; i < 4; i++)
      send({i[1:0], 30'(i * 4)}, i[0], $urandom, 4'(i + 3), 3'(i));
    check_eq("t3_full", 32'(cmd_ready), 32'h0);
    pready = 1'b1;
    send(32'h8000_0100, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b111);
    steps(8);
    check_eq("t3_no_second_setup", 32'(psel), 32'h0);
    check_eq("t3_rsp_held", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    steps(30);
    check_eq("t3_drained", 32'(busy), 32'h0);

    // Slave error on a read, then a clean read
    pslverr = 1'b1;
    prdata = 32'h0BAD_0BAD;
    send(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
    steps(3);
    check_eq("t4_err", 32'(rsp_err), 32'h1);
    pslverr = 1'b0;
    prdata = 32'h600D_600D;
    send(32'h4000_0024, 1'b0, 32'h0, 4'h0, 3'b000);
    steps(3);
    check_eq("t4_err_clear", 32'(rsp_err), 32'h0);
    check_eq("t4_rdata", rsp_rdata, 32'h600D_600D);
    step();

    // Reset in the middle of ACCESS
    pready = 1'b0;
    send(32'h8000_0040, 1'b1, 32'h1111_2222, 4'hC, 3'b100);
    steps(2);
    check_eq("t5_in_access", 32'(penable), 32'h1);
    pulse_reset();
    pready = 1'b1;
    steps(5);
    check_eq("t5_no_stale_rsp", 32'(rsp_valid), 32'h0);

    // Slave never ready
    pready = 1'b0;
    send(32'hC000_0080, 1'b0, 32'h0, 4'hF, 3'b011);
    steps(100);
`ifndef APB_TIMEOUT_EN
    check_eq("t6_still_waiting", 32'(penable), 32'h1);
    check_eq("t6_no_rsp", 32'(rsp_valid), 32'h0);
`endif
    pready = 1'b1;
    steps(5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom_range(0, 15));
      cmd_prot  = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 9) < 7);
      pready    = ($urandom_range(0, 9) < 6);
      prdata    = $urandom;
      pslverr   = ($urandom_range(0, 9) < 2);
      step();
    end

    // Drain
    cmd_valid = 1'b0;
    pready = 1'b1;
    rsp_ready = 1'b1;
    steps(30);
    check_eq("final_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
